// File: rtl/mops_issue_scheduler_pkg.sv
// Shared control types for the BN254 pairing datapath: micro-op fields, issue FSM states
// and pipeline latency constants used by the issue scheduler.
package mops_issue_scheduler_pkg;

    // Stage latencies: read, preadd, QPMM, cmul, postadd, write, RAM write-enable.
    localparam int LAT_READ    = 2;
    localparam int LAT_PREADD  = 1;
    localparam int LAT_QPMM    = 4;
    localparam int LAT_CMUL    = 58;
    localparam int LAT_POSTADD = 1;
    localparam int LAT_WRITE   = 2;
    localparam int LAT_WE      = 1;

    localparam int SCHED_PIPE_DEPTH  = LAT_READ + LAT_PREADD + LAT_QPMM + LAT_CMUL +
                                       LAT_POSTADD + LAT_WRITE + LAT_WE;
    localparam int SCHED_ADDR_W      = 9;
    localparam int SCHED_CTRL_W      = 16;
    localparam int SCHED_PC_W        = 12;
    localparam int SCHED_ENTRY_SHIFT = 8;

    // Opaque pm/cm/pom/pos/me control bits carried through to the datapath.
    typedef logic [SCHED_CTRL_W-1:0] micro_ops_t;

    typedef struct packed {
        logic                    last;
        logic                    we;
        logic [SCHED_ADDR_W-1:0] dst;
        logic [SCHED_ADDR_W-1:0] src1;
        logic [SCHED_ADDR_W-1:0] src0;
        micro_ops_t              ctrl;
    } sched_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_e;

endpackage

// File: rtl/mops_issue_scheduler_hazard_scoreboard.sv
// In-flight destination scoreboard: shift register of issued ops (index 0 = age 1) with a
// parallel RAW compare against the op waiting to issue. Built only with HAZARD_CHECK_EN.
`ifdef HAZARD_CHECK_EN
module mops_issue_scheduler_hazard_scoreboard
    import mops_issue_scheduler_pkg::*;
#(
    parameter int DEPTH  = SCHED_PIPE_DEPTH,
    parameter int ADDR_W = SCHED_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              push_we_i,
    input  logic [ADDR_W-1:0] push_dst_i,
    input  logic [ADDR_W-1:0] src0_i,
    input  logic [ADDR_W-1:0] src1_i,
    output logic              hazard_o,
    output logic              any_valid_o
);
    logic [DEPTH-1:0]             inflight_q;
    logic [DEPTH-1:0]             writes_q;
    logic [DEPTH-1:0][ADDR_W-1:0] dst_q;
    logic [DEPTH-1:0]             match;

    // inflight_q tracks every issued op so drain timing does not depend on we;
    // only writes_q entries can ever raise a hazard.
    always_ff @(posedge clk) begin
        if (!rstn_i || clear_i) begin
            inflight_q <= '0;
            writes_q   <= '0;
        end else begin
            inflight_q <= {inflight_q[DEPTH-2:0], push_i};
            writes_q   <= {writes_q[DEPTH-2:0], push_i & push_we_i};
        end
    end

    always_ff @(posedge clk) begin
        dst_q <= {dst_q[DEPTH-2:0], push_dst_i};
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match[gi] = writes_q[gi] &&
                           ((dst_q[gi] == src0_i) || (dst_q[gi] == src1_i));
    end

    assign hazard_o    = |match;
    assign any_valid_o = |inflight_q;

endmodule
`endif

// File: rtl/mops_issue_scheduler.sv
// Issue-stage scheduler: fetches micro-ops from the program ROM and issues them in order,
// one per cycle. RAW hazard stalling and stall_cnt are enabled by HAZARD_CHECK_EN.
module mops_issue_scheduler
    import mops_issue_scheduler_pkg::*;
#(
    parameter int PIPE_DEPTH  = SCHED_PIPE_DEPTH,
    parameter int ADDR_W      = SCHED_ADDR_W,
    parameter int CTRL_W      = SCHED_CTRL_W,
    parameter int PC_W        = SCHED_PC_W,
    parameter int ENTRY_SHIFT = SCHED_ENTRY_SHIFT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            abort,
    input  logic            start,
    input  logic [3:0]      n_func,
    output logic [PC_W-1:0] prog_addr,
    output logic            prog_en,
    input  sched_op_t       prog_data,
    output logic            issue_valid,
    output sched_op_t       issue_op,
    output logic            busy,
    output logic            done,
    output logic [23:0]     stall_cnt
);
    // The op record layout is fixed in the package; the width parameters must agree with it.
    if (ADDR_W != SCHED_ADDR_W || CTRL_W != SCHED_CTRL_W) begin : g_width_check
        $error("ADDR_W/CTRL_W must match sched_op_t field widths");
    end

    sched_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    sched_op_t       op_q, op_d;
    logic            prime_wait_q, prime_wait_d;
    logic [PC_W-1:0] entry_pc;
    logic            hazard;
    logic            drain_empty;

    assign entry_pc  = PC_W'(n_func) << ENTRY_SHIFT;
    assign prog_addr = pc_q;

    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            op_q         <= '0;
            prime_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            op_q         <= op_d;
            prime_wait_q <= prime_wait_d;
        end
    end

    // PRIME spans two cycles: the first waits out the ROM read of the entry op while the
    // second fetch is already issued, so ISSUE always finds the next op on prog_data.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        op_d         = op_q;
        prime_wait_d = prime_wait_q;
        prog_en      = 1'b0;
        issue_valid  = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d         = entry_pc;
                    prime_wait_d = 1'b1;
                    state_d      = S_PRIME;
                end
            end
            S_PRIME: begin
                prog_en = 1'b1;
                pc_d    = pc_q + 1'b1;
                if (prime_wait_q) begin
                    prime_wait_d = 1'b0;
                end else begin
                    op_d    = prog_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // On a stall prog_en stays low so the ROM keeps presenting the next op.
                if (!hazard) begin
                    issue_valid = 1'b1;
                    if (op_q.last) begin
                        state_d = S_DRAIN;
                    end else begin
                        op_d    = prog_data;
                        prog_en = 1'b1;
                        pc_d    = pc_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_op = '0;
        if (issue_valid) begin
            issue_op = op_q;
        end
    end

    assign busy = (state_q != S_IDLE) && !done;

`ifdef HAZARD_CHECK_EN
    logic        sb_hazard;
    logic        sb_any_valid;
    logic        start_accept;
    logic [23:0] stall_cnt_q;

    mops_issue_scheduler_hazard_scoreboard #(
        .DEPTH  (PIPE_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rstn_i      (rstn),
        .clear_i     (abort),
        .push_i      (issue_valid),
        .push_we_i   (op_q.we),
        .push_dst_i  (op_q.dst),
        .src0_i      (op_q.src0),
        .src1_i      (op_q.src1),
        .hazard_o    (sb_hazard),
        .any_valid_o (sb_any_valid)
    );

    assign hazard       = (state_q == S_ISSUE) && sb_hazard;
    assign drain_empty  = !sb_any_valid;
    assign start_accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            stall_cnt_q <= '0;
        end else if (hazard) begin
            stall_cnt_q <= stall_cnt_q + 24'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);

    logic [DRAIN_W-1:0] drain_cnt_q;

    // Loaded on the final issue; reaches zero exactly PIPE_DEPTH cycles later.
    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            drain_cnt_q <= '0;
        end else if (issue_valid && op_q.last) begin
            drain_cnt_q <= DRAIN_W'(PIPE_DEPTH);
        end else if (state_q == S_DRAIN && drain_cnt_q != '0) begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
        end
    end

    assign hazard      = 1'b0;
    assign drain_empty = (drain_cnt_q == '0);
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_mops_issue_scheduler.sv
// Directed bench for mops_issue_scheduler; expectations follow HAZARD_CHECK_EN when defined.
module tb_mops_issue_scheduler;
    import mops_issue_scheduler_pkg::*;

`ifdef HAZARD_CHECK_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn, abort, start;
    logic [3:0]  n_func;
    logic [11:0] prog_addr;
    logic        prog_en;
    sched_op_t   prog_data;
    logic        issue_valid;
    sched_op_t   issue_op;
    logic        busy, done;
    logic [23:0] stall_cnt;

    sched_op_t   rom [4096];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          iss_cyc [$];
    sched_op_t   iss_op  [$];
    int          done_cyc;
    int          busy_err, zero_err;

    mops_issue_scheduler dut (
        .clk         (clk),
        .rstn        (rstn),
        .abort       (abort),
        .start       (start),
        .n_func      (n_func),
        .prog_addr   (prog_addr),
        .prog_en     (prog_en),
        .prog_data   (prog_data),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .busy        (busy),
        .done        (done),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Program ROM with registered read and output hold while prog_en is low.
    always_ff @(posedge clk) begin
        if (prog_en) prog_data <= rom[prog_addr];
    end

    function automatic sched_op_t mk_op(input logic last, input logic we, input logic [8:0] dst,
                                        input logic [8:0] src1, input logic [8:0] src0,
                                        input logic [15:0] ctrl);
        sched_op_t o;
        o.last = last; o.we = we; o.dst = dst; o.src1 = src1; o.src0 = src0; o.ctrl = ctrl;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle after the call returns is cycle 1 of the run (start was sampled in cycle 0).
    task automatic launch(input logic [3:0] f);
        step();
        start  = 1'b1;
        n_func = f;
        step();
        start  = 1'b0;
        n_func = 4'd0;
    endtask

    task automatic run_to_done(input int limit, input int poke_cyc);
        iss_cyc.delete();
        iss_op.delete();
        done_cyc = -1;
        busy_err = 0;
        zero_err = 0;
        for (int c = 1; c <= limit; c++) begin
            if (c == poke_cyc) begin
                start  = 1'b1;
                n_func = 4'd7;
            end
            if (issue_valid === 1'b1) begin
                iss_cyc.push_back(c);
                iss_op.push_back(issue_op);
                $display("[TB] cycle %0d issue op=%h", c, issue_op);
            end else if (issue_op !== '0) begin
                zero_err++;
            end
            if (done === 1'b1) begin
                done_cyc = c;
                if (busy !== 1'b0) busy_err++;
                break;
            end
            if (busy !== 1'b1) busy_err++;
            step();
            start  = 1'b0;
            n_func = 4'd0;
        end
        tests_run++;
        if (done_cyc < 0) begin
            tests_failed++;
            $display("FAIL run_timeout: no done within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (prog_addr !== 12'd0 || prog_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_prog: addr=%h en=%b, required 000/0", prog_addr, prog_en);
        end
        tests_run++;
        if (issue_valid !== 1'b0 || issue_op !== '0) begin
            tests_failed++;
            $display("FAIL reset_issue: valid=%b op=%h, required 0/0", issue_valid, issue_op);
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_status: busy=%b done=%b stall=%0d, required 0/0/0",
                     busy, done, stall_cnt);
        end
    endtask

    task automatic test_independent();
        int exp_c [4] = '{3, 4, 5, 6};
        for (int i = 0; i < 4; i++)
            rom[12'h200 + i] = mk_op(i == 3, 1'b1, 9'(10 + i), 9'(40 + i), 9'(70 + i),
                                     16'hA000 + 16'(i));
        rom[12'h700] = mk_op(1'b1, 1'b1, 9'd500, 9'd501, 9'd502, 16'hDEAD);
        launch(4'd2);
        tests_run++;
        if (prog_en !== 1'b1 || prog_addr !== 12'h200) begin
            tests_failed++;
            $display("FAIL indep_fetch: en=%b addr=%h, required 1/200", prog_en, prog_addr);
        end
        run_to_done(300, 0);
        tests_run++;
        if (iss_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL indep_count: %0d issues, required 4", iss_cyc.size());
        end
        for (int i = 0; i < 4 && i < iss_cyc.size(); i++) begin
            tests_run++;
            if (iss_cyc[i] != exp_c[i] || iss_op[i] !== rom[12'h200 + i]) begin
                tests_failed++;
                $display("FAIL indep_issue%0d: cycle %0d op %h, required cycle %0d op %h",
                         i, iss_cyc[i], iss_op[i], exp_c[i], rom[12'h200 + i]);
            end
        end
        tests_run++;
        if (done_cyc != 76 || stall_cnt !== 24'd0 || busy_err != 0 || zero_err != 0) begin
            tests_failed++;
            $display("FAIL indep_done: done@%0d stall=%0d busy_err=%0d zero_err=%0d, required 76/0/0/0",
                     done_cyc, stall_cnt, busy_err, zero_err);
        end
        step();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL indep_after: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_raw();
        int exp1  = HZ ? 73 : 4;
        int expst = HZ ? 69 : 0;
        rom[12'h100] = mk_op(1'b0, 1'b1, 9'd5, 9'd2, 9'd1, 16'h1111);
        rom[12'h101] = mk_op(1'b1, 1'b1, 9'd6, 9'd3, 9'd5, 16'h2222);
        launch(4'd1);
        run_to_done(400, 0);
        tests_run++;
        if (iss_cyc.size() != 2) begin
            tests_failed++;
            $display("FAIL raw_count: %0d issues, required 2", iss_cyc.size());
        end else begin
            tests_run++;
            if (iss_cyc[0] != 3 || iss_cyc[1] != exp1 || iss_op[1] !== rom[12'h101]) begin
                tests_failed++;
                $display("FAIL raw_issue: cycles %0d,%0d op1 %h, required 3,%0d op1 %h",
                         iss_cyc[0], iss_cyc[1], iss_op[1], exp1, rom[12'h101]);
            end
        end
        tests_run++;
        if (stall_cnt !== 24'(expst) || done_cyc != exp1 + 70) begin
            tests_failed++;
            $display("FAIL raw_done: stall=%0d done@%0d, required %0d/%0d",
                     stall_cnt, done_cyc, expst, exp1 + 70);
        end
        step();
        tests_run++;
        if (stall_cnt !== 24'(expst)) begin
            tests_failed++;
            $display("FAIL raw_hold: stall=%0d after done, required %0d", stall_cnt, expst);
        end
    endtask

    task automatic test_we0();
        rom[12'h300] = mk_op(1'b0, 1'b0, 9'd5, 9'd8, 9'd9, 16'h3333);
        rom[12'h301] = mk_op(1'b1, 1'b1, 9'd6, 9'd5, 9'd7, 16'h4444);
        launch(4'd3);
        run_to_done(300, 0);
        tests_run++;
        if (iss_cyc.size() != 2 || iss_cyc[0] != 3 || iss_cyc[1] != 4) begin
            tests_failed++;
            $display("FAIL we0_issue: %0d issues first@%0d, required 2 at 3,4",
                     iss_cyc.size(), (iss_cyc.size() > 0) ? iss_cyc[0] : -1);
        end
        tests_run++;
        if (stall_cnt !== 24'd0 || done_cyc != 74) begin
            tests_failed++;
            $display("FAIL we0_done: stall=%0d done@%0d, required 0/74", stall_cnt, done_cyc);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 10; i++)
            rom[12'h400 + i] = mk_op(i == 9, 1'b1, 9'(20 + i), 9'(120 + i), 9'(100 + i),
                                     16'h4000 + 16'(i));
        rom[12'h500] = mk_op(1'b0, 1'b1, 9'd30, 9'd21, 9'd20, 16'h5000);
        rom[12'h501] = mk_op(1'b1, 1'b1, 9'd31, 9'd20, 9'd21, 16'h5001);
        launch(4'd4);
        step();
        step();
        step();
        tests_run++;
        if (issue_valid !== 1'b1 || issue_op !== rom[12'h401]) begin
            tests_failed++;
            $display("FAIL abort_issue2: valid=%b op=%h, required 1/%h",
                     issue_valid, issue_op, rom[12'h401]);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || issue_valid !== 1'b0 || done !== 1'b0 || issue_op !== '0) begin
            tests_failed++;
            $display("FAIL abort_idle: busy=%b valid=%b done=%b op=%h, required all 0",
                     busy, issue_valid, done, issue_op);
        end
        launch(4'd5);
        run_to_done(300, 0);
        tests_run++;
        if (iss_cyc.size() != 2) begin
            tests_failed++;
            $display("FAIL abort_rerun_count: %0d issues, required 2", iss_cyc.size());
        end else begin
            tests_run++;
            if (iss_cyc[0] != 3 || iss_cyc[1] != 4 ||
                iss_op[0] !== rom[12'h500] || iss_op[1] !== rom[12'h501]) begin
                tests_failed++;
                $display("FAIL abort_rerun: cycles %0d,%0d ops %h %h, required 3,4 %h %h",
                         iss_cyc[0], iss_cyc[1], iss_op[0], iss_op[1],
                         rom[12'h500], rom[12'h501]);
            end
        end
        tests_run++;
        if (stall_cnt !== 24'd0 || done_cyc != 74) begin
            tests_failed++;
            $display("FAIL abort_rerun_done: stall=%0d done@%0d, required 0/74",
                     stall_cnt, done_cyc);
        end
    endtask

    task automatic test_start_busy();
        launch(4'd2);
        run_to_done(300, 3);
        tests_run++;
        if (iss_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL busy_start_count: %0d issues, required 4", iss_cyc.size());
        end
        for (int i = 0; i < 4 && i < iss_cyc.size(); i++) begin
            tests_run++;
            if (iss_cyc[i] != 3 + i || iss_op[i] !== rom[12'h200 + i]) begin
                tests_failed++;
                $display("FAIL busy_start_issue%0d: cycle %0d op %h, required cycle %0d op %h",
                         i, iss_cyc[i], iss_op[i], 3 + i, rom[12'h200 + i]);
            end
        end
        tests_run++;
        if (done_cyc != 76) begin
            tests_failed++;
            $display("FAIL busy_start_done: done@%0d, required 76", done_cyc);
        end
    endtask

    task automatic test_reset_drain();
        int n_done = 0;
        launch(4'd2);
        for (int c = 1; c < 20; c++) step();
        tests_run++;
        if (busy !== 1'b1 || issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_state: busy=%b valid=%b at cycle 20, required 1/0",
                     busy, issue_valid);
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        tests_run++;
        if (prog_addr !== 12'd0 || prog_en !== 1'b0 || issue_valid !== 1'b0 || issue_op !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 24'd0) begin
            tests_failed++;
            $display("FAIL drain_reset: addr=%h en=%b valid=%b busy=%b done=%b stall=%0d, required all 0",
                     prog_addr, prog_en, issue_valid, busy, done, stall_cnt);
        end
        for (int c = 0; c < 80; c++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            step();
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL drain_quiet: %0d busy/done cycles after reset, required 0", n_done);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = '0;
        rstn   = 1'b0;
        abort  = 1'b0;
        start  = 1'b0;
        n_func = 4'd0;
        step();
        step();
        step();
        test_reset();
        rstn = 1'b1;
        test_independent();
        test_raw();
        test_we0();
        test_abort();
        test_start_busy();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
